// File: rtl/can_fault_sequencer_if.sv
// Signal bundle between the bit-level error detectors, the fault sequencer
// and the TX bit driver.
//
// Handshake: there is no valid/ready pair. samplePoint is the sole
// qualifier. Every input is looked at only on a clock where samplePoint=1,
// and the strobes (error inputs, overloadReq, txOkay, rxOkay) mean
// "this happened during this bit time". Outputs are registered and stay
// stable between sample points.
interface can_fault_sequencer_if;
    logic       samplePoint;
    logic       canRX;
    logic       txMode;
    logic       bitErro;
    logic       stuffErro;
    logic       crcErro;
    logic       formErro;
    logic       ackErro;
    logic       overloadReq;
    logic       txOkay;
    logic       rxOkay;
    logic       canTX;
    logic       interframe;
    logic       busy;
    logic       errPassive;
    logic       busOff;
    logic [8:0] tec;
    logic [7:0] rec;
    logic [2:0] dbgState;

    // Detector/driver side: drives the bit-time inputs, observes the sequencer.
    modport master (
        output samplePoint, canRX, txMode, bitErro, stuffErro, crcErro,
               formErro, ackErro, overloadReq, txOkay, rxOkay,
        input  canTX, interframe, busy, errPassive, busOff, tec, rec, dbgState
    );

    // Sequencer side.
    modport slave (
        input  samplePoint, canRX, txMode, bitErro, stuffErro, crcErro,
               formErro, ackErro, overloadReq, txOkay, rxOkay,
        output canTX, interframe, busy, errPassive, busOff, tec, rec, dbgState
    );
endinterface

// File: rtl/can_fault_sequencer.sv
// CAN fault sequencer: emits error/overload flags, delimiters and
// intermission, keeps the TEC/REC counters and the fault-confinement
// state (error-active / error-passive / bus-off) including bus-off recovery.
// The FSM state is exported on dbgState for observation.
module can_fault_sequencer #(
    parameter int FLAG_BITS     = 6,
    parameter int DELIM_BITS    = 8,
    parameter int IFS_BITS      = 3,
    parameter int RECOVERY_SEQS = 128
) (
    input logic                  clock,
    input logic                  reset,
    can_fault_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERR_FLAG   = 3'd1,
        OVL_FLAG   = 3'd2,
        DELIM_WAIT = 3'd3,
        DELIM      = 3'd4,
        IFS        = 3'd5,
        BUS_OFF    = 3'd6
    } state_t;

    localparam int SEQ_W = $clog2(RECOVERY_SEQS + 1);

    // Last value of bitCnt in each timed state. The first delimiter bit is
    // consumed in DELIM_WAIT, so DELIM itself counts one bit fewer.
    localparam logic [3:0]       FLAG_LAST  = 4'(FLAG_BITS - 1);
    localparam logic [3:0]       DELIM_LAST = 4'((DELIM_BITS >= 2) ? DELIM_BITS - 2 : 0);
    localparam logic [3:0]       IFS_LAST   = 4'(IFS_BITS - 1);
    localparam logic [3:0]       RUN_LAST   = 4'd10;
    localparam logic [SEQ_W-1:0] SEQ_LAST   = SEQ_W'(RECOVERY_SEQS - 1);

    state_t             state_q, state_n;
    logic [3:0]         bit_cnt_q, bit_cnt_n;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_n;
    logic [8:0]         tec_q, tec_n;
    logic [7:0]         rec_q, rec_n;
    logic               bus_off_q, bus_off_n;
    logic               can_tx_q, can_tx_n;
    logic               ifs_q, ifs_n;
    logic               busy_q, busy_n;
    logic               passive_n;
    logic               any_err;

    assign any_err = bus.bitErro | bus.stuffErro | bus.crcErro | bus.formErro | bus.ackErro;

    // Next-state, counter and registered-output computation; nothing moves without samplePoint.
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        seq_cnt_n = seq_cnt_q;
        tec_n     = tec_q;
        rec_n     = rec_q;
        bus_off_n = bus_off_q;

        if (bus.samplePoint) begin
            if (state_q == BUS_OFF) begin
                // Recovery: count runs of 11 recessive bits; dominant restarts the run only.
                if (bus.canRX) begin
                    if (bit_cnt_q == RUN_LAST) begin
                        bit_cnt_n = '0;
                        if (seq_cnt_q == SEQ_LAST) begin
                            seq_cnt_n = '0;
                            tec_n     = '0;
                            rec_n     = '0;
                            bus_off_n = 1'b0;
                            state_n   = IDLE;
                        end else begin
                            seq_cnt_n = seq_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end
                end else begin
                    bit_cnt_n = '0;
                end
            end else begin
                // Successful frames roll the counters back first.
                if (bus.txOkay && tec_q != 9'd0) begin
                    tec_n = tec_q - 9'd1;
                end
                if (bus.rxOkay) begin
                    if (rec_q > 8'd127) begin
                        rec_n = 8'd119;
                    end else if (rec_q != 8'd0) begin
                        rec_n = rec_q - 8'd1;
                    end
                end

                bit_cnt_n = bit_cnt_q + 4'd1;

                unique case (state_q)
                    IDLE: begin
                        if (any_err) begin
                            state_n = ERR_FLAG;
                            if (bus.txMode) begin
                                tec_n = tec_n + 9'd8;
                            end else if (rec_n != 8'hFF) begin
                                rec_n = rec_n + 8'd1;
                            end
                        end else if (bus.overloadReq) begin
                            state_n = OVL_FLAG;
                        end
                    end
                    ERR_FLAG, OVL_FLAG: begin
                        if (bit_cnt_q == FLAG_LAST) begin
                            state_n = DELIM_WAIT;
                        end
                    end
                    DELIM_WAIT: begin
                        // Superimposed flags from other nodes keep us here.
                        if (bus.canRX) begin
                            state_n = (DELIM_BITS <= 1) ? IFS : DELIM;
                        end
                    end
                    DELIM: begin
                        if (!bus.canRX) begin
                            state_n = OVL_FLAG;
                        end else if (bit_cnt_q == DELIM_LAST) begin
                            state_n = IFS;
                        end
                    end
                    IFS: begin
                        if (bus.overloadReq || !bus.canRX) begin
                            state_n = OVL_FLAG;
                        end else if (bit_cnt_q == IFS_LAST) begin
                            state_n = IDLE;
                        end
                    end
                    default: state_n = IDLE;
                endcase

                // TEC past 255 overrides whatever the sequence was doing.
                if (tec_n[8]) begin
                    bus_off_n = 1'b1;
                    state_n   = BUS_OFF;
                end

                if (state_n != state_q) begin
                    bit_cnt_n = '0;
                    seq_cnt_n = '0;
                end
            end
        end

        passive_n = ((tec_n > 9'd127) || (rec_n > 8'd127)) && !bus_off_n;
        can_tx_n  = !((state_n == OVL_FLAG) || ((state_n == ERR_FLAG) && !passive_n));
        ifs_n     = (state_n == IFS);
        busy_n    = (state_n != IDLE) && (state_n != BUS_OFF);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            seq_cnt_q <= '0;
            tec_q     <= '0;
            rec_q     <= '0;
            bus_off_q <= 1'b0;
            can_tx_q  <= 1'b1;
            ifs_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            seq_cnt_q <= seq_cnt_n;
            tec_q     <= tec_n;
            rec_q     <= rec_n;
            bus_off_q <= bus_off_n;
            can_tx_q  <= can_tx_n;
            ifs_q     <= ifs_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.canTX      = can_tx_q;
    assign bus.interframe = ifs_q;
    assign bus.busy       = busy_q;
    assign bus.busOff     = bus_off_q;
    assign bus.errPassive = ((tec_q > 9'd127) || (rec_q > 8'd127)) && !bus_off_q;
    assign bus.tec        = tec_q;
    assign bus.rec        = rec_q;
    assign bus.dbgState   = state_q;

endmodule

// File: doc/can_fault_sequencer.md
# can_fault_sequencer

Sequences the CAN node's response to detected errors and overload conditions. It sits between the bit-level detectors (error/overload detection, stuff, CRC, EOF checks) and the TX bit driver. On each sample point it:
- emits error flags, overload flags, delimiters and intermission;
- maintains the transmit and receive error counters (TEC, REC);
- tracks fault-confinement state (error-active, error-passive, bus-off), including bus-off recovery.

## Interface

Parameters:
- FLAG_BITS, 6, length of error/overload flag in bit times
- DELIM_BITS, 8, length of error/overload delimiter in bit times
- IFS_BITS, 3, intermission length in bit times
- RECOVERY_SEQS, 128, count of 11-recessive-bit sequences needed to leave bus-off

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- samplePoint  input  1  one-clock strobe per bit time; all state and counter updates happen only on clocks with samplePoint=1
- canRX  input  1  sampled bus level (0 = dominant)
- txMode  input  1  1 = node is the current transmitter
- bitErro, stuffErro, crcErro, formErro, ackErro  input  1 each  error detected this bit, active-high
- overloadReq  input  1  overload condition detected, active-high
- txOkay  input  1  frame transmitted successfully (one strobe)
- rxOkay  input  1  frame received successfully (one strobe)
- canTX  output  1  bit to drive (0 = dominant)
- interframe  output  1  high during intermission
- busy  output  1  high in any state except IDLE and BUS_OFF
- errPassive  output  1  fault state is error-passive
- busOff  output  1  fault state is bus-off
- tec  output  9  transmit error counter
- rec  output  8  receive error counter

## Operation

- **Error detection:** anyErr = OR of the five error inputs.
- **States:** IDLE, ERR_FLAG, OVL_FLAG, DELIM_WAIT, DELIM, IFS, BUS_OFF. A 4-bit bit counter `bitCnt` is cleared on every state entry.
- **IDLE** (canTX=1):
  - anyErr → ERR_FLAG.
  - Otherwise overloadReq → OVL_FLAG.
  - Errors take priority over overload.
- **ERR_FLAG:**
  - canTX=0 if error-active; canTX=1 if error-passive.
  - After FLAG_BITS sample points → DELIM_WAIT.
- **OVL_FLAG:**
  - canTX=0 regardless of fault state.
  - After FLAG_BITS sample points → DELIM_WAIT.
- **DELIM_WAIT** (canTX=1):
  - Stays while canRX=0, absorbing superimposed flags.
  - First sample with canRX=1 → DELIM; that bit counts as delimiter bit 1.
- **DELIM** (canTX=1):
  - After DELIM_BITS recessive bits in total → IFS.
  - canRX=0 inside DELIM → OVL_FLAG (form/overload condition); no counter change.
- **IFS** (canTX=1, interframe=1):
  - After IFS_BITS bits → IDLE.
  - overloadReq or canRX=0 during IFS → OVL_FLAG.
- **Error-input gating:** error inputs are ignored outside IDLE.
- **Counter update on anyErr in IDLE**, applied the same edge as the ERR_FLAG entry:
  - txMode=1: tec += 8.
  - txMode=0: rec += 1, saturating at 255.
- **Successful frames:**
  - txOkay: tec -= 1 if tec>0.
  - rxOkay: rec -= 1 if 1≤rec≤127; rec = 119 if rec>127.
  - txOkay and rxOkay apply in any state except BUS_OFF.
- **Fault state** (combinational from counters; busOff is registered):
  - errPassive = (tec>127 || rec>127) && !busOff.
  - tec>255 sets busOff and forces state BUS_OFF, overriding the current state.
- **BUS_OFF:**
  - canTX=1; all inputs except canRX are ignored.
  - Count consecutive recessive samples. Each run of 11 increments the sequence counter and restarts the run count; canRX=0 restarts the run only.
  - After RECOVERY_SEQS sequences: tec=0, rec=0, busOff=0 → IDLE.

## Timing

- Reset values: state=IDLE, canTX=1, interframe=0, busy=0, errPassive=0, busOff=0, tec=0, rec=0, all internal counters=0.
- Reset mid-sequence (flag, delimiter or bus-off) returns immediately to the reset values.
- **Latency:** outputs are registered.
  - An error strobed at sample point k makes canTX=0 visible from the clock after k.
  - That value holds until the edge at sample point k+FLAG_BITS.
- A full active error frame with a quiet bus occupies exactly FLAG_BITS+DELIM_BITS+IFS_BITS = 17 sample points from the entry edge back to IDLE.
- samplePoint=0 clocks change nothing; samplePoint held high counts one bit per clock.
- **tec width:** tec is 9 bits. It cannot exceed 263 before bus-off; no wrap is possible.

## Test plan

- **Active error frame:** reset, txMode=0, crcErro strobed at one sample point. Expected: canTX=0 for 6 bits, 1 for 8 bits, interframe=1 for 3 bits, then IDLE; rec=1, busy low after 17 bits.
- **Error-passive threshold:** 16 transmitter errors (txMode=1, bitErro). Expected: tec=128, errPassive=1. The next error frame drives a 6-bit flag with canTX=1 throughout.
- **Superimposed flags:** after ERR_FLAG, hold canRX=0 for 5 extra bits. Expected: state stays in DELIM_WAIT, then an 8-bit delimiter after the first recessive bit; total frame length 22 bits.
- **Error vs. overload priority:** stuffErro and overloadReq on the same sample. Expected: ERR_FLAG entered, rec+1. Separately, overloadReq during IFS bit 2 gives OVL_FLAG with no counter change.
- **Bus-off and recovery:** drive tec to 256 via 32 tx errors. Expected: busOff=1, canTX=1. Then 128×11 recessive bits with one dominant bit inserted mid-run. Expected: recovery only after that run restarts; finally tec=0, rec=0, IDLE.
- **rec rollback and reset:** rec=130 followed by rxOkay gives rec=119. Asserting reset during OVL_FLAG immediately gives canTX=1 and all counters 0.
